// File: rtl/stream_pkt_arb.sv
`timescale 1ns/1ps
// Packet-aware round-robin arbiter: grants one source per whole packet onto a
// single registered stream, tags beats with the source index, and optionally truncates oversize packets.
module stream_pkt_arb #(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned MAX_PKT_BEATS = 0,
    localparam int unsigned PORT_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_PORTS-1:0]            s_last,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_header,
    input  logic [NUM_PORTS-1:0]            s_drop,
    input  logic [NUM_PORTS-1:0]            s_valid,
    output logic [NUM_PORTS-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic                            m_last,
    output logic [DATA_WIDTH-1:0]           m_header,
    output logic                            m_drop,
    output logic [PORT_WIDTH-1:0]           m_port,
    output logic                            m_valid,
    input  logic                            m_ready
);

    localparam int unsigned CNT_WIDTH = (MAX_PKT_BEATS > 0) ? $clog2(MAX_PKT_BEATS + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (MAX_PKT_BEATS > 0) ? CNT_WIDTH'(MAX_PKT_BEATS - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_FLUSH
    } state_t;

    state_t                  state;
    logic [PORT_WIDTH-1:0]   grant;
    logic [PORT_WIDTH-1:0]   last_grant;
    logic [CNT_WIDTH-1:0]    count;
    logic [PORT_WIDTH-1:0]   arb_idx;
    logic                    out_load;
    logic                    beat_acc;
    logic                    truncate;
    logic [DATA_WIDTH-1:0]   g_data;
    logic [DATA_WIDTH-1:0]   g_header;
    logic                    g_last;
    logic                    g_drop;

    // Round-robin pick: first valid port after last_grant, wrapping; lowest offset wins.
    always_comb begin
        arb_idx = '0;
        for (int k = int'(NUM_PORTS); k >= 1; k--) begin
            if (s_valid[(int'(last_grant) + k) % int'(NUM_PORTS)]) begin
                arb_idx = PORT_WIDTH'((int'(last_grant) + k) % int'(NUM_PORTS));
            end
        end
    end

    assign out_load = ~m_valid | m_ready;

    always_comb begin
        s_ready = '0;
        if ((state == ST_PKT && out_load) || state == ST_FLUSH) begin
            s_ready[grant] = 1'b1;
        end
    end

    assign g_data   = s_data[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign g_header = s_header[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign g_last   = s_last[grant];
    assign g_drop   = s_drop[grant];
    assign beat_acc = s_valid[grant] & s_ready[grant];
    assign truncate = (MAX_PKT_BEATS > 0) && (count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            m_valid    <= 1'b0;
            grant      <= '0;
            last_grant <= PORT_WIDTH'(NUM_PORTS - 1);
            count      <= '0;
        end else begin
            if (m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (|s_valid) begin
                        grant <= arb_idx;
                        count <= '0;
                        state <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (beat_acc) begin
                        m_valid  <= 1'b1;
                        m_data   <= g_data;
                        m_header <= g_header;
                        m_port   <= grant;
                        count    <= count + CNT_WIDTH'(1);
                        if (g_last) begin
                            m_last     <= 1'b1;
                            m_drop     <= g_drop;
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end else if (truncate) begin
                            // Oversize: close the packet here, mark it bad, discard the tail.
                            m_last <= 1'b1;
                            m_drop <= 1'b1;
                            state  <= ST_FLUSH;
                        end else begin
                            m_last <= 1'b0;
                            m_drop <= g_drop;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (beat_acc && g_last) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_pkt_arb.sv
`timescale 1ns/1ps
// Bench for stream_pkt_arb: per-port source queues, a transaction-level
// model of packet order/truncation, and per-cycle output and ready checks.
module tb_stream_pkt_arb;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int MAXB = 4;
    localparam int PW = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NP*DW-1:0]   s_data;
    logic [NP-1:0]      s_last;
    logic [NP*DW-1:0]   s_header;
    logic [NP-1:0]      s_drop;
    logic [NP-1:0]      s_valid;
    logic [NP-1:0]      s_ready;
    logic [DW-1:0]      m_data;
    logic               m_last;
    logic [DW-1:0]      m_header;
    logic               m_drop;
    logic [PW-1:0]      m_port;
    logic               m_valid;
    logic               m_ready;

    stream_pkt_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_PKT_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_last(s_last), .s_header(s_header), .s_drop(s_drop),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_last(m_last), .m_header(m_header), .m_drop(m_drop),
        .m_port(m_port), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [DW-1:0] header;
        logic          drop;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [DW-1:0] header;
        logic          drop;
        logic [PW-1:0] port;
    } out_t;

    typedef struct {
        out_t o;
        int   cyc;
    } obs_t;

    beat_t src_q[NP][$];
    out_t  exp_q[$];
    obs_t  log_q[$];
    bit    mr_pat[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int gap_pct = 0;
    bit mr_rand = 0;
    logic [NP-1:0] acc_s = '0;

    // Transaction-level model state
    bit in_pkt = 0;
    bit pending = 0;
    bit stall = 0;
    int cur = 0;
    int exp_grant = 0;
    int last_win = NP - 1;
    int pkt_cnt = 0;
    int first_sv = -1;
    int first_mv = -1;
    int acc_total[NP];
    out_t prev_o, o_now, e_now;
    logic [NP-1:0] acc, exp_rdy;
    int g;
    bit trunc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int lw, input logic [NP-1:0] v);
        for (int k = 1; k <= NP; k++) begin
            if (v[(lw + k) % NP]) return (lw + k) % NP;
        end
        return -1;
    endfunction

    // Per-cycle monitor and model, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_pkt = 0;
            pending = 0;
            stall = 0;
            last_win = NP - 1;
            exp_q.delete();
            acc_s = '0;
        end else begin
            o_now = out_t'({m_data, m_last, m_header, m_drop, m_port});
            if (first_sv < 0 && s_valid != '0) first_sv = cyc;
            if (first_mv < 0 && m_valid) first_mv = cyc;

            if (stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_hold", 32'(o_now), 32'(prev_o));
            end
            stall = m_valid && !m_ready;
            prev_o = o_now;

            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(o_now), 32'hFFFFFFFF);
                end else begin
                    e_now = exp_q.pop_front();
                    chk("out_beat", 32'(o_now), 32'(e_now));
                end
                log_q.push_back('{o_now, cyc});
            end

            if (!in_pkt && !pending) begin
                chk("idle_ready", 32'(s_ready), 32'd0);
                if (s_valid != '0) begin
                    exp_grant = rr_pick(last_win, s_valid);
                    pending = 1;
                end
            end else begin
                g = in_pkt ? cur : exp_grant;
                exp_rdy = '0;
                if ((in_pkt && pkt_cnt >= MAXB) || !m_valid || m_ready) exp_rdy = NP'(1) << g;
                chk("s_ready", 32'(s_ready), 32'(exp_rdy));
            end

            acc = s_valid & s_ready;
            if ($countones(acc) > 1) chk("multi_accept", 32'(acc), 32'd0);
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    if (!in_pkt) begin
                        chk("grant_pending", 32'(pending), 32'd1);
                        chk("grant_port", 32'(p), 32'(exp_grant));
                        in_pkt = 1;
                        pending = 0;
                        cur = p;
                        pkt_cnt = 0;
                    end else begin
                        chk("pkt_port", 32'(p), 32'(cur));
                    end
                    pkt_cnt++;
                    acc_total[p]++;
                    trunc = (pkt_cnt == MAXB) && !s_last[p];
                    if (pkt_cnt <= MAXB) begin
                        exp_q.push_back(out_t'({s_data[p*DW +: DW], s_last[p] | trunc,
                                                s_header[p*DW +: DW], s_drop[p] | trunc, PW'(p)}));
                    end
                    if (s_last[p]) begin
                        in_pkt = 0;
                        last_win = p;
                    end
                end
            end
            acc_s = acc;
        end
    end

    // Source and sink driver, just after each rising edge.
    initial begin
        s_valid = '0; s_data = '0; s_last = '0; s_header = '0; s_drop = '0; m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (acc_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() == 0) begin
                    s_valid[i] = 1'b0;
                end else if (!s_valid[i] || acc_s[i]) begin
                    if (int'($urandom_range(99)) < gap_pct) begin
                        s_valid[i] = 1'b0;
                    end else begin
                        s_data[i*DW +: DW]   = src_q[i][0].data;
                        s_last[i]            = src_q[i][0].last;
                        s_header[i*DW +: DW] = src_q[i][0].header;
                        s_drop[i]            = src_q[i][0].drop;
                        s_valid[i]           = 1'b1;
                    end
                end
            end
            if (mr_pat.size() > 0) m_ready = mr_pat.pop_front();
            else if (mr_rand) m_ready = ($urandom_range(99) < 70);
            else m_ready = 1'b1;
        end
    end

    function automatic beat_t mk(input logic [7:0] d, input bit l, input logic [7:0] h, input bit dr);
        beat_t b;
        b.data = d; b.last = l; b.header = h; b.drop = dr;
        return b;
    endfunction

    task automatic send_pkt(input int port, input int len, input logic [7:0] base,
                            input logic [7:0] hdr, input bit drop_last);
        for (int b = 0; b < len; b++) begin
            src_q[port].push_back(mk(DW'(base + 8'(b)), b == len - 1, hdr, (b == len - 1) && drop_last));
        end
    endtask

    function automatic bit quiet();
        for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) return 0;
        return exp_q.size() == 0 && !m_valid && !in_pkt && !pending;
    endfunction

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (n < max_cyc && !quiet()) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("drain", 32'(quiet()), 32'd1);
    endtask

    task automatic start_test();
        @(negedge clk);
        #2;
        log_q.delete();
        first_sv = -1;
        first_mv = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < NP; i++) src_q[i].delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int base1, n;
        for (int i = 0; i < NP; i++) acc_total[i] = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;

        // Single 3-beat packet from port 0
        start_test();
        src_q[0].push_back(mk(8'h11, 0, 8'h10, 0));
        src_q[0].push_back(mk(8'h22, 0, 8'h10, 0));
        src_q[0].push_back(mk(8'h33, 1, 8'h10, 0));
        wait_drain(50);
        chk("t1_count", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("t1_d0", 32'(log_q[0].o.data), 32'h11);
            chk("t1_d1", 32'(log_q[1].o.data), 32'h22);
            chk("t1_d2", 32'(log_q[2].o.data), 32'h33);
            chk("t1_last", 32'({log_q[0].o.last, log_q[1].o.last, log_q[2].o.last}), 32'b001);
            chk("t1_port", 32'(log_q[2].o.port), 32'd0);
            chk("t1_consec", 32'(log_q[2].cyc - log_q[0].cyc), 32'd2);
        end
        chk("t1_latency", 32'(first_mv - first_sv), 32'd2);

        // Three contending ports after reset: order 0,1,2,0 with one idle cycle between packets
        do_reset();
        start_test();
        send_pkt(0, 2, 8'h20, 8'h01, 0);
        send_pkt(1, 2, 8'h30, 8'h02, 0);
        send_pkt(2, 2, 8'h40, 8'h03, 0);
        send_pkt(0, 2, 8'h50, 8'h04, 0);
        wait_drain(100);
        chk("t2_count", 32'(log_q.size()), 32'd8);
        if (log_q.size() == 8) begin
            chk("t2_ports", 32'({log_q[0].o.port, log_q[2].o.port, log_q[4].o.port, log_q[6].o.port}),
                32'({2'd0, 2'd1, 2'd2, 2'd0}));
            chk("t2_data", 32'({log_q[1].o.data, log_q[3].o.data, log_q[5].o.data, log_q[7].o.data}),
                32'h31_41_51_21 == 0 ? 32'd0 : 32'h21_31_41_51);
            chk("t2_gap", 32'(log_q[2].cyc - log_q[1].cyc), 32'd2);
            chk("t2_inpkt", 32'(log_q[5].cyc - log_q[4].cyc), 32'd1);
        end

        // Back-pressure 1,0,0,1 during a 4-beat packet
        start_test();
        send_pkt(1, 4, 8'h60, 8'h61, 0);
        mr_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        wait_drain(100);
        chk("t3_count", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            chk("t3_data", 32'({log_q[0].o.data, log_q[1].o.data, log_q[2].o.data, log_q[3].o.data}),
                32'h60616263);
            chk("t3_last", 32'({log_q[0].o.last, log_q[1].o.last, log_q[2].o.last, log_q[3].o.last}),
                32'b0001);
        end

        // Oversize 6-beat packet on port 1, port 2 waiting behind it
        start_test();
        base1 = acc_total[1];
        send_pkt(1, 6, 8'h70, 8'h71, 0);
        repeat (2) @(negedge clk);
        #2;
        send_pkt(2, 2, 8'h80, 8'h81, 0);
        wait_drain(100);
        chk("t4_count", 32'(log_q.size()), 32'd6);
        chk("t4_consumed", 32'(acc_total[1] - base1), 32'd6);
        if (log_q.size() == 6) begin
            chk("t4_beat4", 32'({log_q[3].o.data, log_q[3].o.last, log_q[3].o.drop, log_q[3].o.port}),
                32'({8'h73, 1'b1, 1'b1, 2'd1}));
            chk("t4_beat3_last", 32'(log_q[2].o.last), 32'd0);
            chk("t4_next", 32'({log_q[4].o.port, log_q[4].o.data}), 32'({2'd2, 8'h80}));
        end

        // Drop request and header on port 3's last beat
        start_test();
        src_q[3].push_back(mk(8'h90, 0, 8'hA5, 0));
        src_q[3].push_back(mk(8'h91, 1, 8'hA5, 1));
        wait_drain(50);
        chk("t5_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("t5_last", 32'({log_q[1].o.last, log_q[1].o.drop, log_q[1].o.header, log_q[1].o.port}),
                32'({1'b1, 1'b1, 8'hA5, 2'd3}));
            chk("t5_first_drop", 32'(log_q[0].o.drop), 32'd0);
        end

        // Reset on the second beat of a packet
        start_test();
        base1 = acc_total[1];
        send_pkt(1, 4, 8'hB0, 8'hB1, 0);
        n = 0;
        while (acc_total[1] == base1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_beat", 32'(acc_total[1] - base1), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("t6_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_s_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < NP; i++) src_q[i].delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        start_test();
        send_pkt(2, 2, 8'hC0, 8'hC2, 0);
        send_pkt(0, 2, 8'hD0, 8'hD0, 0);
        wait_drain(100);
        chk("t6_count", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            chk("t6_first_port", 32'(log_q[0].o.port), 32'd0);
            chk("t6_second_port", 32'(log_q[2].o.port), 32'd2);
        end

        // Randomized traffic: gaps, back-pressure, lengths across the truncation bound
        gap_pct = 25;
        mr_rand = 1;
        n = 0;
        for (int it = 0; it < 20000 && n < 200; it++) begin
            @(negedge clk);
            #2;
            for (int p = 0; p < NP; p++) begin
                if (n < 200 && src_q[p].size() < 6 && $urandom_range(1) == 1) begin
                    send_pkt(p, int'($urandom_range(1, 6)), 8'($urandom), 8'($urandom), 1'($urandom));
                    n++;
                end
            end
        end
        gap_pct = 0;
        mr_rand = 0;
        wait_drain(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish, expected finish before 900000 ns");
        $fatal(1, "timeout");
    end

endmodule
